// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg: shared constants and the occupancy-width helper for the
// elastic register pipeline.
package reg_pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 2;

  // Bits needed to hold an occupancy of 0..DEPTH+1 (DEPTH+1 when the skid
  // entry is present), so the same width serves both builds.
  function automatic int clog2_depth(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage : reg_pipe_pkg

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage: one valid/data register of the elastic pipeline.
// Loads from upstream when i_load is high; data only changes when the
// upstream word is valid, so a bubble never overwrites the held word.
module reg_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_load,
  input  logic             i_up_valid,
  input  logic [WIDTH-1:0] i_up_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Stage register: reset clears everything, flush only drops the valid bit.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every stage sampling the pre-edge
    // value of its neighbour, which is what makes the chain a pipeline.
    if (!rst) begin
      r_valid <= 1'b0;
      // NOTE: the data word is reset too because out_data is observable
      // and must read zero after reset, not whatever was left behind.
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_up_valid;
      if (i_up_valid) r_data <= i_up_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule : reg_pipe_stage

// File: rtl/reg_pipe.sv
// reg_pipe: elastic WIDTH-bit register pipeline of DEPTH stages with
// valid/ready handshake, bubble collapsing, synchronous flush and an
// occupancy count.
// Build option: define REG_PIPE_SKID_EN to add a one-entry skid register in
// front of stage 0, making in_ready a pure register output (capacity
// DEPTH+1). Without it, in_ready is combinational from out_ready.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int CW    = clog2_depth(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  logic             w_v [DEPTH];
  logic [WIDTH-1:0] w_d [DEPTH];
  logic [DEPTH:0]   w_r;
  logic             w_s0_valid;
  logic [WIDTH-1:0] w_s0_data;
  logic             w_in_fire;
  logic             w_out_fire;
  logic [CW-1:0]    r_count;

  // Ready ripples back from the output: a stage accepts when it is empty or
  // the stage ahead of it is moving, so empty stages always collapse.
  always_comb begin
    // NOTE: a full default before the loop guarantees every bit is written
    // on every pass, so no latch can be inferred.
    w_r        = '0;
    w_r[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_r[i] = ~w_v[i] | w_r[i+1];
    end
  end

`ifdef REG_PIPE_SKID_EN
  logic             w_sv;
  logic [WIDTH-1:0] w_sd;
  logic             w_skid_load;

  // Empty skid captures the input only when stage 0 is blocked; a full skid
  // empties (loads a bubble) as soon as stage 0 takes its word.
  assign w_skid_load = w_sv ? w_r[0] : ~w_r[0];

  reg_pipe_stage #(.WIDTH(WIDTH)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (flush),
    .i_load     (w_skid_load),
    .i_up_valid (~w_sv & in_valid),
    .i_up_data  (in_data),
    .o_valid    (w_sv),
    .o_data     (w_sd)
  );

  assign in_ready   = ~w_sv & ~flush;
  assign w_s0_valid = w_sv | in_valid;
  assign w_s0_data  = w_sv ? w_sd : in_data;
`else
  assign in_ready   = w_r[0] & ~flush;
  assign w_s0_valid = in_valid;
  assign w_s0_data  = in_data;
`endif

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             w_up_valid;
    logic [WIDTH-1:0] w_up_data;

    if (g == 0) begin : g_first
      assign w_up_valid = w_s0_valid;
      assign w_up_data  = w_s0_data;
    end else begin : g_rest
      assign w_up_valid = w_v[g-1];
      assign w_up_data  = w_d[g-1];
    end

    reg_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .i_flush    (flush),
      .i_load     (w_r[g]),
      .i_up_valid (w_up_valid),
      .i_up_data  (w_up_data),
      .o_valid    (w_v[g]),
      .o_data     (w_d[g])
    );
  end

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = w_v[DEPTH-1] & out_ready;

  // Occupancy: +1 per accepted word, -1 per delivered word, cleared by flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_in_fire && !w_out_fire) begin
      r_count <= r_count + CW'(1);
    end else if (!w_in_fire && w_out_fire) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign out_valid = w_v[DEPTH-1];
  assign out_data  = w_d[DEPTH-1];
  assign count     = r_count;

endmodule : reg_pipe

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: self-checking bench for reg_pipe. A queue of in-flight words,
// each tagged with the slot it occupies, predicts out_valid/out_data/
// in_ready/count every cycle; directed phases pin the model with literals.
module tb_reg_pipe;

  localparam int DEPTH = 2;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH + 2);
`ifdef REG_PIPE_SKID_EN
  localparam int CAP   = DEPTH + 1;
`else
  localparam int CAP   = DEPTH;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;

  int n_tests = 0;
  int n_fail  = 0;

  reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Slot -1 is the skid entry, 0..DEPTH-1 the stages, DEPTH-1 the output.
  typedef struct {
    logic [WIDTH-1:0] data;
    int               pos;
  } word_t;

  word_t            q[$];
  logic [WIDTH-1:0] m_last_out = '0;
  bit               m_started  = 1'b0;

  function automatic bit model_in_ready();
    if (flush) return 1'b0;
`ifdef REG_PIPE_SKID_EN
    return !(q.size() > 0 && q[q.size()-1].pos == -1);
`else
    return (q.size() < DEPTH) || out_ready;
`endif
  endfunction

  always @(posedge clk) begin
    automatic bit in_fire = in_valid && model_in_ready();
    automatic int limit   = DEPTH;
    automatic word_t w;
    m_started <= 1'b1;
    if (!rst) begin
      q.delete();
      m_last_out = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (q.size() > 0 && q[0].pos == DEPTH - 1 && out_ready) void'(q.pop_front());
      // Every word moves up one slot if the slot ahead is free after the
      // word in front of it has moved.
      foreach (q[k]) begin
        if (q[k].pos + 1 < limit) begin
          q[k].pos = q[k].pos + 1;
          if (q[k].pos == DEPTH - 1) m_last_out = q[k].data;
        end
        limit = q[k].pos;
      end
      if (in_fire) begin
        w.data = in_data;
        w.pos  = (limit > 0) ? 0 : -1;
        if (w.pos == DEPTH - 1) m_last_out = w.data;
        q.push_back(w);
      end
    end
  end

  // Compare process: every cycle once the first edge has happened.
  always @(negedge clk) begin
    if (m_started) begin
      check("m_count",     32'(count),     32'(q.size()));
      check("m_out_valid", 32'(out_valid), 32'(q.size() > 0 && q[0].pos == DEPTH - 1));
      check("m_out_data",  32'(out_data),  32'(m_last_out));
      check("m_in_ready",  32'(in_ready),  32'(model_in_ready()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drain();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 3) @(posedge clk);
    #1;
  endtask

  // Fill the pipe with incrementing words until in_ready drops.
  task automatic fill(input logic [WIDTH-1:0] base);
    in_valid  = 1'b1;
    in_data   = base;
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!in_ready) break;
      @(posedge clk); #1;
      in_data = in_data + 8'd1;
    end
    @(posedge clk); #1;
  endtask

  logic [WIDTH-1:0] got[8];
  int               n_got;
  int               idx;
  bit               acc;
  int               ready_pct;

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;

    // Reset held three cycles with a word offered.
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_count",     32'(count),     32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Streaming 0x01..0x10 back to back with out_ready high.
    out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(k);
      @(negedge clk);
      check("stream_valid", 32'(out_valid), 32'(k > DEPTH));
      if (k > DEPTH) check("stream_data", 32'(out_data), 32'(k - DEPTH));
      check("stream_count", 32'(count), 32'((k - 1 < DEPTH) ? k - 1 : DEPTH));
      @(posedge clk); #1;
    end
    drain();

    // Back-pressure: offer 4 words with out_ready low.
    out_ready = 1'b0;
    idx = 1; in_valid = 1'b1; in_data = 8'd1;
    repeat (6) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc && idx < 4) begin idx++; in_data = 8'(idx); end
      else if (acc) in_valid = 1'b0;
    end
    @(negedge clk);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_count",    32'(count),    32'(CAP));
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; n_got = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid && n_got < 8) begin got[n_got] = out_data; n_got++; end
    end
    check("bp_n_out", 32'(n_got), 32'(CAP));
    for (int i = 0; i < CAP; i++) check("bp_order", 32'(got[i]), 32'(i + 1));
    @(posedge clk); #1;
    drain();

    // Bubble collapse: word in stage 0 only, second word still accepted.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h31;
    @(posedge clk); #1;
    in_data = 8'h32;
    @(negedge clk);
    check("bub_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bub_count",     32'(count),     32'd2);
    check("bub_out_valid", 32'(out_valid), 32'd1);
    check("bub_out_data",  32'(out_data),  32'h31);
    @(posedge clk); #1;
    drain();

    // Flush mid-stream with a word offered.
    fill(8'h50);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    @(negedge clk);
    check("fl_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_count",     32'(count),     32'd0);
    repeat (4) begin
      @(negedge clk);
      check("fl_no_ghost", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Full-through: in and out in the same cycle on a full pipe.
    fill(8'h60);
    @(negedge clk);
    check("ft_full_count", 32'(count), 32'(CAP));
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("ft_count", 32'(count), 32'(DEPTH));
    @(posedge clk); #1;
    drain();

    // Randomized traffic with occasional flush and reset.
    for (int blk = 0; blk < 15; blk++) begin
      ready_pct = $urandom_range(10, 100);
      repeat (200) begin
        rst       = ($urandom_range(0, 199) != 0);
        flush     = ($urandom_range(0, 31) == 0);
        in_valid  = $urandom_range(0, 1);
        in_data   = 8'($urandom);
        out_ready = ($urandom_range(1, 100) <= ready_pct);
        @(posedge clk); #1;
      end
    end
    rst = 1'b1;
    drain();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_reg_pipe
